reorder_buffer: RTL and testbench

In-order commit buffer that sits between issue/execute and the renaming register file.
- Issue reserves a ROB slot per instruction and receives its tag (alloc_id); the register file records that tag against the destination register.
- Execution units report results by tag.
- The ROB retires entries strictly in allocation order, driving the register file's write/commit port (write enable, tag, register address, data).

---
 rtl/reorder_buffer.sv | 101 ++++++++++
 tb/tb_reorder_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order commit buffer: issue reserves tagged slots, execution completes them by tag, retirement drives the register-file write port.
// Commit outputs are registered, so a completion to the head entry shows up on commit_we two cycles later.
module reorder_buffer #(
    parameter int ID_W   = 4,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_has_dest,
    input  logic [REG_W-1:0]  alloc_dest,
    output logic [ID_W-1:0]   alloc_id,
    input  logic              done_valid,
    input  logic [ID_W-1:0]   done_id,
    input  logic [DATA_W-1:0] done_data,
    input  logic              pred_miss,
    output logic              commit_we,
    output logic [ID_W-1:0]   commit_id,
    output logic [REG_W-1:0]  commit_addr,
    output logic [DATA_W-1:0] commit_data,
    output logic [ID_W:0]     count,
    output logic              empty,
    output logic              full
);
    localparam int DEPTH = 1 << ID_W;

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  r_has_dest;
    logic [REG_W-1:0]  r_dest [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [ID_W-1:0]   r_head;
    logic [ID_W-1:0]   r_tail;
    logic [ID_W:0]     r_count;

    logic w_alloc;
    logic w_commit;
    logic w_done_hit;

    assign full        = (r_count == (ID_W+1)'(DEPTH));
    assign empty       = (r_count == '0);
    assign count       = r_count;
    assign alloc_ready = !full;
    assign alloc_id    = r_tail;

    assign w_alloc    = alloc_valid && alloc_ready;
    assign w_commit   = r_valid[r_head] && r_done[r_head];
    assign w_done_hit = done_valid && r_valid[done_id];

    // Control state. Completion is applied before allocation so a fresh slot always starts not-done.
    always_ff @(posedge clk) begin
        if (nrst || pred_miss) begin
            r_valid   <= '0;
            r_done    <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            commit_we <= 1'b0;
            if (nrst) begin
                commit_id   <= '0;
                commit_addr <= '0;
                commit_data <= '0;
            end
        end else begin
            if (w_done_hit) begin
                r_done[done_id] <= 1'b1;
            end
            if (w_alloc) begin
                r_valid[r_tail]    <= 1'b1;
                r_done[r_tail]     <= 1'b0;
                r_has_dest[r_tail] <= alloc_has_dest;
                r_tail             <= r_tail + 1'b1;
            end
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
                commit_we       <= r_has_dest[r_head];
                commit_id       <= r_head;
                commit_addr     <= r_dest[r_head];
                commit_data     <= r_data[r_head];
            end else begin
                commit_we <= 1'b0;
            end
            r_count <= r_count + (ID_W+1)'(w_alloc) - (ID_W+1)'(w_commit);
        end
    end

    // Payload storage needs no reset; it is only read behind a valid+done entry.
    always_ff @(posedge clk) begin
        if (!nrst && !pred_miss) begin
            if (w_done_hit) begin
                r_data[done_id] <= done_data;
            end
            if (w_alloc) begin
                r_dest[r_tail] <= alloc_dest;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a vector table for the sequential flow plus a hand-written fill/wrap sequence.
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        nrst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic        alloc_has_dest;
    logic [4:0]  alloc_dest;
    logic [3:0]  alloc_id;
    logic        done_valid;
    logic [3:0]  done_id;
    logic [31:0] done_data;
    logic        pred_miss;
    logic        commit_we;
    logic [3:0]  commit_id;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;
    logic [4:0]  count;
    logic        empty;
    logic        full;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.ID_W(4), .REG_W(5), .DATA_W(32)) dut (
        .clk(clk), .nrst(nrst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_has_dest(alloc_has_dest), .alloc_dest(alloc_dest), .alloc_id(alloc_id),
        .done_valid(done_valid), .done_id(done_id), .done_data(done_data),
        .pred_miss(pred_miss),
        .commit_we(commit_we), .commit_id(commit_id), .commit_addr(commit_addr),
        .commit_data(commit_data),
        .count(count), .empty(empty), .full(full)
    );

    typedef struct {
        logic        av;
        logic        hd;
        logic [4:0]  dst;
        logic        dv;
        logic [3:0]  did;
        logic [31:0] ddat;
        logic        pm;
        logic [3:0]  e_id;
        logic        e_we;
        logic [3:0]  e_cid;
        logic [4:0]  e_caddr;
        logic [31:0] e_cdata;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid    = 1'b0;
        alloc_has_dest = 1'b0;
        alloc_dest     = '0;
        done_valid     = 1'b0;
        done_id        = '0;
        done_data      = '0;
        pred_miss      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nrst = 1'b1;
        tick();
        tick();
        nrst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ready", 32'(alloc_ready), 1);
        chk("rst_we", 32'(commit_we), 0);
        chk("rst_cid", 32'(commit_id), 0);
        chk("rst_caddr", 32'(commit_addr), 0);
        chk("rst_cdata", commit_data, 0);
        chk("rst_alloc_id", 32'(alloc_id), 0);
    endtask

    initial begin
        // av hd dst dv did ddat pm | id we cid caddr cdata cnt  (expected values are after the edge)
        vq.push_back('{1,1,1, 0,0,0,      0,  0, 0,0,0,0,       1});
        vq.push_back('{1,1,2, 0,0,0,      0,  1, 0,0,0,0,       2});
        vq.push_back('{1,1,3, 0,0,0,      0,  2, 0,0,0,0,       3});
        vq.push_back('{0,0,0, 1,0,'hA,    0,  0, 0,0,0,0,       3});
        vq.push_back('{0,0,0, 0,0,0,      0,  0, 1,0,1,'hA,     2});
        vq.push_back('{0,0,0, 0,0,0,      0,  0, 0,0,1,'hA,     2});
        vq.push_back('{1,1,4, 1,2,'h22,   0,  3, 0,0,1,'hA,     3});
        vq.push_back('{0,0,0, 1,3,'h33,   0,  0, 0,0,1,'hA,     3});
        vq.push_back('{0,0,0, 1,1,'h11,   0,  0, 0,0,1,'hA,     3});
        vq.push_back('{0,0,0, 0,0,0,      0,  0, 1,1,2,'h11,    2});
        vq.push_back('{0,0,0, 0,0,0,      0,  0, 1,2,3,'h22,    1});
        vq.push_back('{0,0,0, 0,0,0,      0,  0, 1,3,4,'h33,    0});
        vq.push_back('{0,0,0, 0,0,0,      0,  0, 0,3,4,'h33,    0});
        // no-destination entry retires silently but still updates the tag/addr/data registers
        vq.push_back('{1,0,7, 0,0,0,      0,  4, 0,3,4,'h33,    1});
        vq.push_back('{0,0,0, 1,4,'h44,   0,  0, 0,3,4,'h33,    1});
        vq.push_back('{0,0,0, 0,0,0,      0,  0, 0,4,7,'h44,    0});
        vq.push_back('{1,1,1, 0,0,0,      0,  5, 0,4,7,'h44,    1});
        vq.push_back('{1,1,2, 0,0,0,      0,  6, 0,4,7,'h44,    2});
        vq.push_back('{1,1,3, 0,0,0,      0,  7, 0,4,7,'h44,    3});
        vq.push_back('{1,1,4, 0,0,0,      0,  8, 0,4,7,'h44,    4});
        vq.push_back('{1,1,5, 0,0,0,      0,  9, 0,4,7,'h44,    5});
        vq.push_back('{0,0,0, 1,7,'h77,   0,  0, 0,4,7,'h44,    5});
        vq.push_back('{0,0,0, 1,8,'h88,   0,  0, 0,4,7,'h44,    5});
        // flush discards the same-cycle alloc and completion
        vq.push_back('{1,1,6, 1,5,'h55,   1, 10, 0,4,7,'h44,    0});
        vq.push_back('{0,0,0, 1,3,'hDEAD, 0,  0, 0,4,7,'h44,    0});
        vq.push_back('{1,1,9, 0,0,0,      0,  0, 0,4,7,'h44,    1});
        vq.push_back('{1,1,10,1,0,'h100,  0,  1, 0,4,7,'h44,    2});
        vq.push_back('{1,1,11,1,1,'h101,  0,  2, 1,0,9,'h100,   2});
        vq.push_back('{1,1,12,1,2,'h102,  0,  3, 1,1,10,'h101,  2});
        vq.push_back('{1,1,13,0,0,0,      0,  4, 1,2,11,'h102,  2});
        vq.push_back('{1,1,14,0,0,0,      0,  5, 0,2,11,'h102,  3});
        vq.push_back('{1,1,15,0,0,0,      0,  6, 0,2,11,'h102,  4});
        vq.push_back('{1,1,16,0,0,0,      0,  7, 0,2,11,'h102,  5});
        vq.push_back('{0,0,0, 1,3,'h103,  0,  0, 0,2,11,'h102,  5});
        // alloc + done to id 4 + commit of head 3 in one cycle
        vq.push_back('{1,1,17,1,4,'h104,  0,  8, 1,3,12,'h103,  5});
        vq.push_back('{0,0,0, 0,0,0,      0,  0, 1,4,13,'h104,  4});
        vq.push_back('{1,1,18,0,0,0,      0,  9, 0,4,13,'h104,  5});

        do_reset();

        foreach (vq[i]) begin
            alloc_valid    = vq[i].av;
            alloc_has_dest = vq[i].hd;
            alloc_dest     = vq[i].dst;
            done_valid     = vq[i].dv;
            done_id        = vq[i].did;
            done_data      = vq[i].ddat;
            pred_miss      = vq[i].pm;
            if (vq[i].av) chk($sformatf("v%0d_alloc_id", i), 32'(alloc_id), 32'(vq[i].e_id));
            tick();
            chk($sformatf("v%0d_we", i), 32'(commit_we), 32'(vq[i].e_we));
            chk($sformatf("v%0d_cid", i), 32'(commit_id), 32'(vq[i].e_cid));
            chk($sformatf("v%0d_caddr", i), 32'(commit_addr), 32'(vq[i].e_caddr));
            chk($sformatf("v%0d_cdata", i), commit_data, vq[i].e_cdata);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vq[i].e_cnt));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vq[i].e_cnt == 0));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vq[i].e_cnt == 16));
        end

        // Fill to full, hold a blocked request, then release it with one commit and check the wrap.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            alloc_valid    = 1'b1;
            alloc_has_dest = 1'b1;
            alloc_dest     = 5'(k);
            chk($sformatf("fill%0d_id", k), 32'(alloc_id), k);
            tick();
        end
        chk("full_count", 32'(count), 16);
        chk("full_flag", 32'(full), 1);
        chk("full_ready", 32'(alloc_ready), 0);
        chk("full_empty", 32'(empty), 0);
        alloc_dest = 5'd20;
        done_valid = 1'b1;
        done_id    = 4'd0;
        done_data  = 32'h55;
        tick();
        done_valid = 1'b0;
        chk("blk1_count", 32'(count), 16);
        chk("blk1_ready", 32'(alloc_ready), 0);
        chk("blk1_we", 32'(commit_we), 0);
        tick();
        chk("rel_we", 32'(commit_we), 1);
        chk("rel_cid", 32'(commit_id), 0);
        chk("rel_caddr", 32'(commit_addr), 0);
        chk("rel_cdata", commit_data, 32'h55);
        chk("rel_count", 32'(count), 15);
        chk("rel_ready", 32'(alloc_ready), 1);
        chk("rel_alloc_id", 32'(alloc_id), 0);
        tick();
        alloc_valid = 1'b0;
        chk("refill_count", 32'(count), 16);
        chk("refill_full", 32'(full), 1);
        chk("refill_we", 32'(commit_we), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
